// File: rtl/gate_generator.sv
// Gate sequencer: delay, then cfg_repeats gates of cfg_width cycles separated by cfg_gap idle cycles.
// Define GATE_GEN_CONTINUOUS_EN to make cfg_repeats==0 mean "repeat until abort or reset".
module gate_generator #(
  parameter int DELAY_BITS  = 16,
  parameter int WIDTH_BITS  = 32,
  parameter int GAP_BITS    = 16,
  parameter int REPEAT_BITS = 16
) (
  input  logic                   tclk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DELAY_BITS-1:0]  cfg_delay,
  input  logic [WIDTH_BITS-1:0]  cfg_width,
  input  logic [GAP_BITS-1:0]    cfg_gap,
  input  logic [REPEAT_BITS-1:0] cfg_repeats,
  output logic                   enable_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [REPEAT_BITS-1:0] gates_emitted
);

  localparam int DW_MAX = (DELAY_BITS > WIDTH_BITS) ? DELAY_BITS : WIDTH_BITS;
  localparam int CNT_W  = (DW_MAX > GAP_BITS) ? DW_MAX : GAP_BITS;

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;

  state_t                 r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [REPEAT_BITS-1:0] r_gates, w_gates_nxt, w_gates_inc;
  logic [WIDTH_BITS-1:0]  r_width;
  logic [GAP_BITS-1:0]    r_gap;
  logic [REPEAT_BITS-1:0] r_repeats;
  logic                   r_done, w_done_nxt;
  logic                   r_aborted, w_aborted_nxt;
  logic                   r_enable;
  logic                   r_armed;
  logic                   w_latch;
  logic                   w_last_gate;

  assign w_gates_inc = r_gates + REPEAT_BITS'(1);

`ifdef GATE_GEN_CONTINUOUS_EN
  assign w_last_gate = (r_repeats != '0) && (w_gates_inc == r_repeats);
`else
  assign w_last_gate = (r_repeats == '0) ? (w_gates_inc == REPEAT_BITS'(1))
                                         : (w_gates_inc == r_repeats);
`endif

  always_comb begin
    w_next_state  = r_state;
    w_cnt_nxt     = r_cnt;
    w_gates_nxt   = r_gates;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_latch       = 1'b0;
    case (r_state)
      IDLE: begin
        // r_armed keeps the first edge after reset release from accepting a start
        if (start && !abort && r_armed && (cfg_width != '0)) begin
          w_latch     = 1'b1;
          w_gates_nxt = '0;
          if (cfg_delay != '0) begin
            w_next_state = DELAY;
            w_cnt_nxt    = CNT_W'(cfg_delay) - CNT_W'(1);
          end else begin
            w_next_state = ACTIVE;
            w_cnt_nxt    = CNT_W'(cfg_width) - CNT_W'(1);
          end
        end
      end
      DELAY, GAP: begin
        if (r_cnt == '0) begin
          w_next_state = ACTIVE;
          w_cnt_nxt    = CNT_W'(r_width) - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_gates_nxt = w_gates_inc;
          if (w_last_gate) begin
            w_next_state = IDLE;
            w_done_nxt   = 1'b1;
          end else if (r_gap != '0) begin
            w_next_state = GAP;
            w_cnt_nxt    = CNT_W'(r_gap) - CNT_W'(1);
          end else begin
            // zero gap: reload and stay ACTIVE so consecutive gates merge
            w_cnt_nxt = CNT_W'(r_width) - CNT_W'(1);
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (abort && (r_state != IDLE)) begin
      w_next_state  = IDLE;
      w_cnt_nxt     = '0;
      w_gates_nxt   = r_gates;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge tclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gates   <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_enable  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_nxt;
      r_gates   <= w_gates_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_enable  <= (w_next_state == ACTIVE);
      r_armed   <= 1'b1;
    end
  end

  // Configuration shadow; only read while busy, so it needs no reset
  always_ff @(posedge tclk) begin
    if (w_latch) begin
      r_width   <= cfg_width;
      r_gap     <= cfg_gap;
      r_repeats <= cfg_repeats;
    end
  end

  assign enable_out    = r_enable;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign gates_emitted = r_gates;

endmodule

// File: tb/tb_gate_generator.sv
// Directed bench for gate_generator; cycle k is the clock period following edge k-1, edge 0 samples start.
module tb_gate_generator;
  logic        tclk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_delay;
  logic [31:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_repeats;
  logic        enable_out, busy, done, aborted;
  logic [15:0] gates_emitted;

  int errs   = 0;
  int checks = 0;

  gate_generator dut (
    .tclk(tclk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_repeats(cfg_repeats), .enable_out(enable_out), .busy(busy),
    .done(done), .aborted(aborted), .gates_emitted(gates_emitted)
  );

  always #5 tclk = ~tclk;

  // Presents cfg and a start pulse so that edge 0 samples them
  task automatic launch(input logic [15:0] d, input logic [31:0] w,
                        input logic [15:0] g, input logic [15:0] r);
    @(negedge tclk);
    cfg_delay = d; cfg_width = w; cfg_gap = g; cfg_repeats = r;
    start = 1'b1; abort = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_delay = 16'd0; cfg_width = 32'd3; cfg_gap = 16'd0; cfg_repeats = 16'd1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (enable_out !== 1'b0) begin errs++; $display("FAIL rst_enable got=%b exp=0", enable_out); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (aborted !== 1'b0) begin errs++; $display("FAIL rst_aborted got=%b exp=0", aborted); end
    checks++; if (gates_emitted !== 16'd0) begin errs++; $display("FAIL rst_gates got=%0d exp=0", gates_emitted); end
    @(negedge tclk); @(negedge tclk);
    reset_n = 1'b1;
    start = 1'b1;
    @(negedge tclk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_early_start busy got=%b exp=0", busy); end
    @(negedge tclk);
  endtask

  task automatic test_basic;
    logic exp_en, exp_done, exp_busy;
    launch(16'd3, 32'd5, 16'd2, 16'd2);
    for (int k = 1; k <= 18; k++) begin
      @(negedge tclk);
      exp_en   = (k >= 4 && k <= 8) || (k >= 11 && k <= 15);
      exp_done = (k == 16);
      exp_busy = (k >= 1 && k <= 15);
      checks++; if (enable_out !== exp_en) begin errs++; $display("FAIL basic_en c%0d got=%b exp=%b", k, enable_out, exp_en); end
      checks++; if (done !== exp_done) begin errs++; $display("FAIL basic_done c%0d got=%b exp=%b", k, done, exp_done); end
      checks++; if (busy !== exp_busy) begin errs++; $display("FAIL basic_busy c%0d got=%b exp=%b", k, busy, exp_busy); end
      if (k == 9) begin
        checks++; if (gates_emitted !== 16'd1) begin errs++; $display("FAIL basic_gates_mid got=%0d exp=1", gates_emitted); end
      end
      if (k == 16 || k == 18) begin
        checks++; if (gates_emitted !== 16'd2) begin errs++; $display("FAIL basic_gates c%0d got=%0d exp=2", k, gates_emitted); end
      end
      start = (k == 5);
      if (k == 2) begin
        cfg_delay = 16'd0; cfg_width = 32'd1; cfg_gap = 16'd0; cfg_repeats = 16'd9;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_merge;
    logic exp_en;
    launch(16'd0, 32'd1, 16'd0, 16'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge tclk);
      start  = 1'b0;
      exp_en = (k >= 1 && k <= 4);
      checks++; if (enable_out !== exp_en) begin errs++; $display("FAIL merge_en c%0d got=%b exp=%b", k, enable_out, exp_en); end
      checks++; if (done !== (k == 5)) begin errs++; $display("FAIL merge_done c%0d got=%b exp=%b", k, done, (k == 5)); end
      if (k == 5) begin
        checks++; if (gates_emitted !== 16'd4) begin errs++; $display("FAIL merge_gates got=%0d exp=4", gates_emitted); end
      end
    end
  endtask

  task automatic test_abort;
    logic exp_en, exp_busy;
    launch(16'd3, 32'd5, 16'd2, 16'd2);
    for (int k = 1; k <= 18; k++) begin
      @(negedge tclk);
      exp_en   = (k >= 4 && k <= 6);
      exp_busy = (k >= 1 && k <= 6);
      checks++; if (enable_out !== exp_en) begin errs++; $display("FAIL abort_en c%0d got=%b exp=%b", k, enable_out, exp_en); end
      checks++; if (busy !== exp_busy) begin errs++; $display("FAIL abort_busy c%0d got=%b exp=%b", k, busy, exp_busy); end
      checks++; if (aborted !== (k == 7)) begin errs++; $display("FAIL abort_pulse c%0d got=%b exp=%b", k, aborted, (k == 7)); end
      checks++; if (done !== 1'b0) begin errs++; $display("FAIL abort_done c%0d got=%b exp=0", k, done); end
      start = 1'b0;
      abort = (k == 6);
    end
    checks++; if (gates_emitted !== 16'd0) begin errs++; $display("FAIL abort_gates got=%0d exp=0", gates_emitted); end
  endtask

  task automatic test_ignore;
    launch(16'd2, 32'd0, 16'd1, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge tclk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL w0_busy c%0d got=%b exp=0", k, busy); end
      checks++; if (enable_out !== 1'b0) begin errs++; $display("FAIL w0_en c%0d got=%b exp=0", k, enable_out); end
    end
    @(negedge tclk);
    cfg_width = 32'd4; start = 1'b1; abort = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge tclk);
      start = 1'b0; abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL sa_busy c%0d got=%b exp=0", k, busy); end
      checks++; if (aborted !== 1'b0) begin errs++; $display("FAIL sa_aborted c%0d got=%b exp=0", k, aborted); end
    end
  endtask

  task automatic test_back_to_back;
    logic exp_en, exp_done;
    launch(16'd0, 32'd2, 16'd0, 16'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge tclk);
      exp_en   = (k >= 1 && k <= 2) || (k >= 4 && k <= 5);
      exp_done = (k == 3) || (k == 6);
      checks++; if (enable_out !== exp_en) begin errs++; $display("FAIL b2b_en c%0d got=%b exp=%b", k, enable_out, exp_en); end
      checks++; if (done !== exp_done) begin errs++; $display("FAIL b2b_done c%0d got=%b exp=%b", k, done, exp_done); end
      if (k == 3 || k == 6) begin
        checks++; if (gates_emitted !== 16'd1) begin errs++; $display("FAIL b2b_gates c%0d got=%0d exp=1", k, gates_emitted); end
      end
      if (k == 4) begin
        checks++; if (gates_emitted !== 16'd0) begin errs++; $display("FAIL b2b_clear got=%0d exp=0", gates_emitted); end
      end
      start = (k == 3);
    end
    start = 1'b0;
  endtask

`ifdef GATE_GEN_CONTINUOUS_EN
  task automatic test_repeats_zero;
    logic exp_en;
    launch(16'd0, 32'd2, 16'd1, 16'd0);
    for (int k = 1; k <= 1000; k++) begin
      @(negedge tclk);
      start  = 1'b0;
      exp_en = ((k - 1) % 3) < 2;
      checks++; if (enable_out !== exp_en) begin errs++; $display("FAIL cont_en c%0d got=%b exp=%b", k, enable_out, exp_en); end
      checks++; if (done !== 1'b0) begin errs++; $display("FAIL cont_done c%0d got=%b exp=0", k, done); end
      if (k == 1000) begin
        checks++; if (gates_emitted !== 16'd333) begin errs++; $display("FAIL cont_gates got=%0d exp=333", gates_emitted); end
        abort = 1'b1;
      end
    end
    @(negedge tclk);
    abort = 1'b0;
    checks++; if (aborted !== 1'b1) begin errs++; $display("FAIL cont_abort got=%b exp=1", aborted); end
    checks++; if (gates_emitted !== 16'd333) begin errs++; $display("FAIL cont_hold got=%0d exp=333", gates_emitted); end
  endtask
`else
  task automatic test_repeats_zero;
    launch(16'd0, 32'd2, 16'd1, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge tclk);
      start = 1'b0;
      checks++; if (enable_out !== (k <= 2)) begin errs++; $display("FAIL rep0_en c%0d got=%b exp=%b", k, enable_out, (k <= 2)); end
      checks++; if (done !== (k == 3)) begin errs++; $display("FAIL rep0_done c%0d got=%b exp=%b", k, done, (k == 3)); end
      if (k == 3) begin
        checks++; if (gates_emitted !== 16'd1) begin errs++; $display("FAIL rep0_gates got=%0d exp=1", gates_emitted); end
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    launch(16'd0, 32'd2, 16'd0, 16'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge tclk);
      start = 1'b0;
      checks++; if (enable_out !== 1'b1) begin errs++; $display("FAIL rmid_en c%0d got=%b exp=1", k, enable_out); end
    end
    checks++; if (gates_emitted !== 16'd1) begin errs++; $display("FAIL rmid_pre_gates got=%0d exp=1", gates_emitted); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (enable_out !== 1'b0) begin errs++; $display("FAIL rmid_en_async got=%b exp=0", enable_out); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy_async got=%b exp=0", busy); end
    checks++; if (gates_emitted !== 16'd0) begin errs++; $display("FAIL rmid_gates got=%0d exp=0", gates_emitted); end
    @(negedge tclk);
    reset_n = 1'b1;
    @(negedge tclk); @(negedge tclk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_merge;
    test_abort;
    test_ignore;
    test_back_to_back;
    test_repeats_zero;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
